// File: rtl/eth_rx_filter_pkg.sv
// Shared types and the destination-address accept rule for the RX DA filter.
// Statistics are enabled by defining ETH_RX_FILTER_STATS_EN.
package eth_rx_filter_pkg;

  localparam int HDR_LEN = 6;
  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    DROP,
    FLUSH
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
  } hbuf_ent_t;

  typedef struct packed {
    logic [47:0] mac;
    logic        filter_en;
    logic        promisc;
    logic        bcast_en;
    logic        mcast_en;
  } cfg_t;

  function automatic logic da_accept(
    input logic [47:0] da,
    input cfg_t        cfg
  );
    logic bc;
    bc = (da == BCAST_ADDR);
    return !cfg.filter_en
        || cfg.promisc
        || (da == cfg.mac)
        || (cfg.bcast_en && bc)
        || (cfg.mcast_en && da[40] && !bc);
  endfunction

endpackage

// File: rtl/eth_rx_hdr_shift.sv
// Header holding buffer: FIFO-ordered shift register with push/pop/clear.
// Entry 0 is the oldest byte; da_o exposes all but the newest slot.
module eth_rx_hdr_shift
  import eth_rx_filter_pkg::*;
#(
  parameter int DEPTH = HDR_LEN,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   rx_clk,
  input  logic                   rx_rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clr_i,
  input  logic [7:0]             data_i,
  input  logic                   user_i,
  output logic [7:0]             head_data_o,
  output logic                   head_user_o,
  output logic [8*(DEPTH-1)-1:0] da_o,
  output logic [CW-1:0]          count_o
);

  hbuf_ent_t       mem_q [DEPTH];
  hbuf_ent_t       mem_d [DEPTH];
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   wr;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    wr      = count_q - CW'(pop_i);
    if (clr_i) begin
      count_d = '0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i+1];
        end
      end
      if (push_i) begin
        mem_d[wr] = '{data: data_i, user: user_i};
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      mem_q   <= '{default: '0};
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    da_o = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      da_o[8*(DEPTH-1-i)-1 -: 8] = mem_q[i].data;
    end
  end

  assign head_data_o = mem_q[0].data;
  assign head_user_o = mem_q[0].user;
  assign count_o     = count_q;

endmodule

// File: rtl/eth_rx_dst_filter.sv
// RX destination-MAC filter: holds the DA, then forwards or drops the frame.
// Define ETH_RX_FILTER_STATS_EN to implement the stat_* counters.
module eth_rx_dst_filter #(
  parameter int CNT_WIDTH = 32,
  parameter int HDR_LEN   = eth_rx_filter_pkg::HDR_LEN
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          cfg_mac_addr,
  input  logic                 cfg_filter_en,
  input  logic                 cfg_promisc,
  input  logic                 cfg_bcast_en,
  input  logic                 cfg_mcast_en,
  output logic [CNT_WIDTH-1:0] stat_accepted,
  output logic [CNT_WIDTH-1:0] stat_dropped,
  output logic [CNT_WIDTH-1:0] stat_runt,
  output logic [CNT_WIDTH-1:0] stat_overrun
);

  import eth_rx_filter_pkg::*;

  localparam int CW = $clog2(HDR_LEN + 1);

  state_e state_q, state_d;
  cfg_t   cfg_q, cfg_d, cfg_in;
  logic   ovr_q, ovr_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;

  logic                      push, pop, clr;
  logic [7:0]                head_data;
  logic                      head_user;
  logic [8*(HDR_LEN-1)-1:0]  da_part;
  logic [CW-1:0]             count;
  logic                      hit;
  logic inc_acc, inc_drop, inc_runt, inc_ovr;

  eth_rx_hdr_shift #(
    .DEPTH (HDR_LEN)
  ) u_shift (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .push_i      (push),
    .pop_i       (pop),
    .clr_i       (clr),
    .data_i      (s_axis_tdata),
    .user_i      (s_axis_tuser),
    .head_data_o (head_data),
    .head_user_o (head_user),
    .da_o        (da_part),
    .count_o     (count)
  );

  assign cfg_in = {cfg_mac_addr, cfg_filter_en, cfg_promisc,
                   cfg_bcast_en, cfg_mcast_en};

  // The decision beat's own byte completes the DA before it is stored.
  assign hit = da_accept({da_part, s_axis_tdata}, cfg_q);

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    ovr_d    = ovr_q;
    push     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tuser_d  = 1'b0;
    inc_acc  = 1'b0;
    inc_drop = 1'b0;
    inc_runt = 1'b0;
    inc_ovr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          cfg_d = cfg_in;
          if (s_axis_tlast) begin
            inc_runt = 1'b1;
          end else begin
            push    = 1'b1;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (s_axis_tvalid) begin
          if (count == CW'(HDR_LEN - 1)) begin
            if (hit) begin
              push    = 1'b1;
              state_d = s_axis_tlast ? FLUSH : PASS;
            end else begin
              clr      = 1'b1;
              inc_drop = 1'b1;
              state_d  = s_axis_tlast ? IDLE : DROP;
            end
          end else if (s_axis_tlast) begin
            clr      = 1'b1;
            inc_runt = 1'b1;
            state_d  = IDLE;
          end else begin
            push = 1'b1;
          end
        end
      end
      PASS: begin
        if (s_axis_tvalid) begin
          push     = 1'b1;
          pop      = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = head_data;
          if (s_axis_tlast) state_d = FLUSH;
        end
      end
      FLUSH: begin
        pop      = 1'b1;
        tvalid_d = 1'b1;
        tdata_d  = head_data;
        // A frame arriving mid-drain is discarded up to its tlast.
        if (s_axis_tvalid) begin
          inc_ovr = !ovr_q;
          ovr_d   = !s_axis_tlast;
        end
        if (count == CW'(1)) begin
          tlast_d = 1'b1;
          tuser_d = head_user;
          inc_acc = 1'b1;
          state_d = ovr_d ? DROP : IDLE;
          ovr_d   = 1'b0;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      ovr_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      ovr_q    <= ovr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [CNT_WIDTH-1:0] acc_q, drop_q, runt_q, ovr_cnt_q;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      acc_q     <= '0;
      drop_q    <= '0;
      runt_q    <= '0;
      ovr_cnt_q <= '0;
    end else begin
      acc_q     <= acc_q + CNT_WIDTH'(inc_acc);
      drop_q    <= drop_q + CNT_WIDTH'(inc_drop);
      runt_q    <= runt_q + CNT_WIDTH'(inc_runt);
      ovr_cnt_q <= ovr_cnt_q + CNT_WIDTH'(inc_ovr);
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
  assign stat_runt     = runt_q;
  assign stat_overrun  = ovr_cnt_q;
`else
  logic stats_unused;
  assign stats_unused  = ^{inc_acc, inc_drop, inc_runt, inc_ovr};
  assign stat_accepted = '0;
  assign stat_dropped  = '0;
  assign stat_runt     = '0;
  assign stat_overrun  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_dst_filter.sv
// Directed bench for eth_rx_dst_filter: forwarding, drop, runt, pacing,
// overrun and mid-frame reset scenarios.
module tb_eth_rx_dst_filter;

  typedef logic [7:0] bq_t[$];

`ifdef ETH_RX_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [47:0] MAC = 48'h0200_0000_0001;

  logic        rx_clk, rx_rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [47:0] cfg_mac_addr;
  logic        cfg_filter_en, cfg_promisc, cfg_bcast_en, cfg_mcast_en;
  logic [31:0] stat_accepted, stat_dropped, stat_runt, stat_overrun;

  eth_rx_dst_filter dut (
    .rx_clk        (rx_clk),
    .rx_rst        (rx_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .cfg_mac_addr  (cfg_mac_addr),
    .cfg_filter_en (cfg_filter_en),
    .cfg_promisc   (cfg_promisc),
    .cfg_bcast_en  (cfg_bcast_en),
    .cfg_mcast_en  (cfg_mcast_en),
    .stat_accepted (stat_accepted),
    .stat_dropped  (stat_dropped),
    .stat_runt     (stat_runt),
    .stat_overrun  (stat_overrun)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  logic [7:0] out_d[$];
  bit         out_l[$];
  bit         out_u[$];
  int         out_c[$];
  int         in_c[$];

  always @(negedge rx_clk) begin
    if (m_axis_tvalid === 1'b1) begin
      out_d.push_back(m_axis_tdata);
      out_l.push_back(m_axis_tlast);
      out_u.push_back(m_axis_tuser);
      out_c.push_back(cyc);
    end
  end

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] sv(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  function automatic bq_t mk_frame(input logic [47:0] da, input int len);
    bq_t f;
    for (int i = 0; i < len; i++) begin
      if (i < 6) f.push_back(da[47-8*i -: 8]);
      else f.push_back(8'(i * 7 + 3));
    end
    return f;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rx_clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    out_d.delete();
    out_l.delete();
    out_u.delete();
    out_c.delete();
    in_c.delete();
  endtask

  task automatic set_cfg(input logic [47:0] mac, input logic fe,
                         input logic pr, input logic bc, input logic mc);
    cfg_mac_addr  = mac;
    cfg_filter_en = fe;
    cfg_promisc   = pr;
    cfg_bcast_en  = bc;
    cfg_mcast_en  = mc;
  endtask

  task automatic send_frame(input bq_t f, input int gap,
                            input logic last_user, input int n);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = f[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == f.size() - 1);
      s_axis_tuser  = (i == f.size() - 1) ? last_user : 1'b0;
      @(posedge rx_clk);
      #1;
      in_c.push_back(cyc);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      idle(gap);
    end
  endtask

  task automatic test_reset();
    rx_rst        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    rx_rst = 1'b0;
    idle(2);
    tests++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      fails++;
      $display("FAIL reset.m_axis got %b want 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    tests++;
    if ({stat_accepted, stat_dropped, stat_runt, stat_overrun} !== 128'd0) begin
      fails++;
      $display("FAIL reset.stats got %0d/%0d/%0d/%0d want 0",
               stat_accepted, stat_dropped, stat_runt, stat_overrun);
    end
  endtask

  task automatic test_unicast();
    bq_t f;
    int  bad_d, bad_c, bad_l;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    f = mk_frame(MAC, 64);
    send_frame(f, 0, 1'b0, 64);
    idle(12);
    tests++;
    if (out_d.size() != 64) begin
      fails++;
      $display("FAIL unicast.count got %0d want 64", out_d.size());
    end else begin
      bad_d = 0; bad_c = 0; bad_l = 0;
      for (int i = 0; i < 64; i++) begin
        if (out_d[i] !== f[i]) bad_d++;
        if (out_c[i] - in_c[i] != 6) bad_c++;
        if (out_l[i] != (i == 63)) bad_l++;
      end
      tests++;
      if (bad_d != 0) begin
        fails++;
        $display("FAIL unicast.data got %0d bad bytes want 0", bad_d);
      end
      tests++;
      if (bad_c != 0) begin
        fails++;
        $display("FAIL unicast.lag got %0d bytes not lagging 6 want 0", bad_c);
      end
      tests++;
      if (bad_l != 0) begin
        fails++;
        $display("FAIL unicast.tlast got %0d misplaced want 0", bad_l);
      end
      tests++;
      if (out_c[63] != in_c[63] + 6) begin
        fails++;
        $display("FAIL unicast.tlast_cycle got %0d want %0d", out_c[63], in_c[63] + 6);
      end
    end
    tests++;
    if (stat_accepted !== sv(1)) begin
      fails++;
      $display("FAIL unicast.stat_accepted got %0d want %0d", stat_accepted, sv(1));
    end
  endtask

  task automatic test_drop();
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(mk_frame(48'h0200_0000_0002, 40), 0, 1'b0, 40);
    idle(12);
    tests++;
    if (out_d.size() != 0) begin
      fails++;
      $display("FAIL drop.count got %0d want 0", out_d.size());
    end
    tests++;
    if (stat_dropped !== sv(1)) begin
      fails++;
      $display("FAIL drop.stat_dropped got %0d want %0d", stat_dropped, sv(1));
    end
  endtask

  task automatic test_bcast_mcast();
    bq_t f;
    int  bad;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b1, 1'b0);
    f = mk_frame(48'hFFFF_FFFF_FFFF, 20);
    send_frame(f, 0, 1'b0, 20);
    idle(12);
    bad = (out_d.size() != 20) ? 1 : 0;
    for (int i = 0; i < out_d.size() && i < 20; i++)
      if (out_d[i] !== f[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bcast_on.frame got %0d bytes (%0d errs) want 20", out_d.size(), bad);
    end
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(f, 0, 1'b0, 20);
    idle(12);
    tests++;
    if (out_d.size() != 0) begin
      fails++;
      $display("FAIL bcast_off.count got %0d want 0", out_d.size());
    end
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b1);
    f = mk_frame(48'h0100_5E00_0001, 16);
    send_frame(f, 0, 1'b0, 16);
    idle(12);
    bad = (out_d.size() != 16) ? 1 : 0;
    for (int i = 0; i < out_d.size() && i < 16; i++)
      if (out_d[i] !== f[i] || out_l[i] != (i == 15)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mcast.frame got %0d bytes (%0d errs) want 16", out_d.size(), bad);
    end
    tests++;
    if ({stat_accepted, stat_dropped} !== {sv(3), sv(2)}) begin
      fails++;
      $display("FAIL bcast_mcast.stats got acc %0d drop %0d want %0d %0d",
               stat_accepted, stat_dropped, sv(3), sv(2));
    end
  endtask

  task automatic test_runt_exact6();
    bq_t f;
    int  bad;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(mk_frame(MAC, 4), 0, 1'b0, 4);
    idle(10);
    tests++;
    if (out_d.size() != 0) begin
      fails++;
      $display("FAIL runt.count got %0d want 0", out_d.size());
    end
    tests++;
    if (stat_runt !== sv(1)) begin
      fails++;
      $display("FAIL runt.stat_runt got %0d want %0d", stat_runt, sv(1));
    end
    clear_mon();
    f = mk_frame(MAC, 6);
    send_frame(f, 0, 1'b0, 6);
    idle(10);
    tests++;
    if (out_d.size() != 6) begin
      fails++;
      $display("FAIL exact6.count got %0d want 6", out_d.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 6; i++)
        if (out_d[i] !== f[i] || out_l[i] != (i == 5) || out_c[i] != in_c[5] + 1 + i)
          bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL exact6.bytes got %0d errs want 0", bad);
      end
    end
    tests++;
    if (stat_accepted !== sv(4)) begin
      fails++;
      $display("FAIL exact6.stat_accepted got %0d want %0d", stat_accepted, sv(4));
    end
  endtask

  task automatic test_paced();
    bq_t f;
    int  bad_d, bad_c, bad_u, ec;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    f = mk_frame(MAC, 20);
    send_frame(f, 9, 1'b1, 20);
    idle(12);
    tests++;
    if (out_d.size() != 20) begin
      fails++;
      $display("FAIL paced.count got %0d want 20", out_d.size());
    end else begin
      bad_d = 0; bad_c = 0; bad_u = 0;
      for (int i = 0; i < 20; i++) begin
        ec = (i < 14) ? in_c[i+6] : in_c[19] + 1 + (i - 14);
        if (out_d[i] !== f[i]) bad_d++;
        if (out_c[i] != ec) bad_c++;
        if (out_u[i] != (i == 19) || out_l[i] != (i == 19)) bad_u++;
      end
      tests++;
      if (bad_d != 0) begin
        fails++;
        $display("FAIL paced.data got %0d errs want 0", bad_d);
      end
      tests++;
      if (bad_c != 0) begin
        fails++;
        $display("FAIL paced.timing got %0d errs want 0", bad_c);
      end
      tests++;
      if (bad_u != 0) begin
        fails++;
        $display("FAIL paced.tuser_tlast got %0d errs want 0", bad_u);
      end
    end
    tests++;
    if (stat_accepted !== sv(5)) begin
      fails++;
      $display("FAIL paced.stat_accepted got %0d want %0d", stat_accepted, sv(5));
    end
  endtask

  task automatic test_back_to_back();
    bq_t a;
    int  bad;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    a = mk_frame(MAC, 20);
    send_frame(a, 0, 1'b0, 20);
    idle(1);
    send_frame(mk_frame(MAC, 10), 0, 1'b0, 10);
    idle(12);
    bad = (out_d.size() != 20) ? 1 : 0;
    for (int i = 0; i < out_d.size() && i < 20; i++)
      if (out_d[i] !== a[i] || out_l[i] != (i == 19)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL overrun.first got %0d bytes (%0d errs) want 20", out_d.size(), bad);
    end
    tests++;
    if ({stat_overrun, stat_accepted} !== {sv(1), sv(6)}) begin
      fails++;
      $display("FAIL overrun.stats got ovr %0d acc %0d want %0d %0d",
               stat_overrun, stat_accepted, sv(1), sv(6));
    end
    clear_mon();
    send_frame(mk_frame(MAC, 8), 0, 1'b0, 8);
    idle(12);
    tests++;
    if (out_d.size() != 8) begin
      fails++;
      $display("FAIL overrun.next got %0d want 8", out_d.size());
    end
  endtask

  task automatic test_reset_midframe();
    bq_t f;
    int  bad;
    clear_mon();
    set_cfg(MAC, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(mk_frame(MAC, 30), 0, 1'b0, 15);
    tests++;
    if (m_axis_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL midreset.pre_valid got %b want 1", m_axis_tvalid);
    end
    #2 rx_rst = 1'b1;
    #1;
    tests++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin
      fails++;
      $display("FAIL midreset.outputs got %b want 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    idle(2);
    rx_rst = 1'b0;
    idle(1);
    clear_mon();
    f = mk_frame(MAC, 12);
    send_frame(f, 0, 1'b0, 12);
    idle(12);
    bad = (out_d.size() != 12) ? 1 : 0;
    for (int i = 0; i < out_d.size() && i < 12; i++)
      if (out_d[i] !== f[i] || out_l[i] != (i == 11)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset.next got %0d bytes (%0d errs) want 12", out_d.size(), bad);
    end
    tests++;
    if (stat_accepted !== sv(1)) begin
      fails++;
      $display("FAIL midreset.stat_accepted got %0d want %0d", stat_accepted, sv(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unicast();
    test_drop();
    test_bcast_mcast();
    test_runt_exact6();
    test_paced();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/eth_rx_dst_filter.md
Name: eth_rx_dst_filter

Overview:
- Sits in rx_clk domain between the 1G RGMII MAC receive AXI-stream output and the RX FIFO input.
- Holds back the first 6 bytes of each frame, compares the destination MAC against configuration, then forwards or silently drops the whole frame.
- Output keeps the MAC's no-backpressure stream semantics. Optional per-frame statistics counters.

Parameters:
- CNT_WIDTH, 32: width of the statistics counters.
- HDR_LEN, 6: bytes held before the accept decision; fixed by the DA field length, not overridable in practice.

Ports:
- rx_clk  input  1  receive clock
- rx_rst  input  1  reset, asynchronous, active-high
- s_axis_tdata  input  8  MAC receive data
- s_axis_tvalid  input  1  data valid (gapped at 10/100 speeds)
- s_axis_tlast  input  1  last byte of frame
- s_axis_tuser  input  1  bad frame flag, meaningful on tlast
- m_axis_tdata  output  8  filtered data to FIFO
- m_axis_tvalid  output  1  valid
- m_axis_tlast  output  1  last
- m_axis_tuser  output  1  bad frame flag (forwarded on tlast)
- cfg_mac_addr  input  48  station address, byte 0 = first on wire = bits [47:40]
- cfg_filter_en  input  1  0 = accept all frames of 6 or more bytes
- cfg_promisc  input  1  accept any DA
- cfg_bcast_en  input  1  accept FF:FF:FF:FF:FF:FF
- cfg_mcast_en  input  1  accept DA with byte0 bit0 = 1 (non-broadcast)
- stat_accepted  output  CNT_WIDTH  frames forwarded
- stat_dropped  output  CNT_WIDTH  frames filtered out
- stat_runt  output  CNT_WIDTH  frames ending before HDR_LEN bytes
- stat_overrun  output  CNT_WIDTH  frames starting while FLUSH is still draining

Behaviour:
- Reset: all m_axis_* = 0, stat_* = 0, state = IDLE, buffer count = 0.
- Config is quasi-static. All cfg_* are latched on the first beat of each frame and used for that frame only.
- Holding buffer: 6-entry shift buffer of {data, tuser}, plus a fill count 0..6.
- States:
  - IDLE: first valid beat pushes byte 0, latches cfg, goes to HDR.
  - HDR: each valid beat pushes one byte.
    - tlast with count < 6 → stat_runt++, clear buffer, go to IDLE. Nothing is output.
    - The beat that brings count to 6 evaluates the decision in the same cycle. Accept → PASS; reject → DROP, stat_dropped++.
    - If that 6th beat also carries tlast, the frame is exactly 6 bytes: accept → FLUSH; reject → IDLE.
  - PASS: each valid input beat pushes the new byte and pops the oldest onto m_axis the next cycle, so output lags input by 6 valid beats. Input tlast → FLUSH.
  - FLUSH: pops one byte per rx_clk cycle, no waiting for input. m_axis_tlast and m_axis_tuser = input tuser are driven on the final popped byte. stat_accepted increments on that output tlast; then go to IDLE.
    - A valid input beat during FLUSH → stat_overrun++, that frame is dropped to its tlast, and the flush completes normally.
  - DROP: discard input until tlast, then go to IDLE.
- Decision (DA = buffer bytes 0..5): accept if !filter_en, promisc, DA == cfg_mac_addr, (bcast_en && DA == all-ones), or (mcast_en && DA[40] && DA != all-ones).
- m_axis_tvalid is a single-cycle pulse per byte; m_axis_tlast/tuser are 0 except on the last byte.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset mid-frame: output ceases immediately with no tlast. The next frame is filtered from its first byte; the downstream FIFO tolerates the truncation.

Optional Feature:
- ETH_RX_FILTER_STATS_EN defined: the four stat_* counters are implemented as specified.
- Not defined: stat_* are tied to 0, counter logic is removed, and the datapath is unchanged.

Decomposition:
- Package eth_rx_filter_pkg:
  - state enum {IDLE, HDR, PASS, DROP, FLUSH}
  - localparam HDR_LEN = 6
  - localparam BCAST_ADDR = 48'hFFFF_FFFF_FFFF
  - function da_accept(da, cfg fields)
- Sub-module eth_rx_hdr_shift: 6-entry shift register with push/pop/clear and count. The top level holds the FSM and counters.

Test Plan:
- filter_en=1, mac=02:00:00:00:00:01, 64-byte frame to that DA, continuous valid → 64 bytes out, each lagging 6 cycles, tlast on byte 64 exactly 6 cycles after input tlast, stat_accepted=1.
- Same config, DA=02:00:00:00:00:02, bcast_en=0 → no m_axis_tvalid; stat_dropped=1.
- DA=FF:FF:FF:FF:FF:FF with bcast_en=1 then 0 → first forwarded, second dropped. DA=01:00:5E:00:00:01 with mcast_en=1 → forwarded.
- 4-byte frame with tlast on byte 4 → no output, stat_runt=1. Exactly 6-byte matching frame → 6 bytes out back-to-back, tlast on 6th.
- 100M pacing (valid every 10th cycle), matching frame with tuser=1 on tlast → output bytes paced with input, m_axis_tuser=1 on the last byte, stat_accepted=1.
- Second frame's first beat arrives 2 cycles after the first frame's tlast → first frame drains fully, second produces no output, stat_overrun=1. Assert rx_rst mid-PASS → outputs 0 at once, next frame accepted normally.
